// File: rtl/router_pkg.sv
// Shared constants, helpers and entry type for the router packet FIFO.
package router_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned DEPTH_DEF     = 16;
  localparam int unsigned LEN_LSB_DEF   = 2;
  localparam int unsigned LEN_W_DEF     = 6;
  localparam int unsigned AF_MARGIN_DEF = 2;

  // Address width for a given depth (ceil(log2(depth))).
  function automatic int unsigned addr_w(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

  // Stored entry at default width: header tag plus data word.
  typedef struct packed {
    logic                  sof;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/router_pkt_fifo_if.sv
// Write/read handshake and status bundle between the router and one channel FIFO.
interface router_pkt_fifo_if import router_pkg::*; #(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
);

  localparam int unsigned AW = addr_w(DEPTH);

  logic              write_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic              read_enb;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              rd_sof;
  logic              rd_eof;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [AW:0]       count;
  logic              pkt_active;
  logic              err_overflow;
  logic              err_underflow;
  logic              err_orphan;

  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, rd_valid, rd_sof, rd_eof, empty, full, almost_full,
           count, pkt_active, err_overflow, err_underflow, err_orphan
  );

  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, rd_valid, rd_sof, rd_eof, empty, full, almost_full,
           count, pkt_active, err_overflow, err_underflow, err_orphan
  );

endinterface

// File: rtl/router_pkt_tracker.sv
// Read-side packet tracker: remaining-length counter, sof/eof markers, orphan detection.
module router_pkt_tracker import router_pkg::*; #(
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             rd_accept,
  input  logic             rd_tag,
  input  logic [LEN_W-1:0] rd_len,
  output logic             rd_sof,
  output logic             rd_eof,
  output logic             pkt_active,
  output logic             err_orphan
);

  logic [LEN_W:0] rem;
  logic [LEN_W:0] rem_load_c;

  // Header reload covers payload plus the trailing parity word.
  assign rem_load_c = (LEN_W+1)'(rd_len) + (LEN_W+1)'(1);
  assign pkt_active = (rem != '0);

  // Advance the packet state on every accepted read; markers pulse only with data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rem        <= '0;
      rd_sof     <= 1'b0;
      rd_eof     <= 1'b0;
      err_orphan <= 1'b0;
    end else if (soft_reset) begin
      rem        <= '0;
      rd_sof     <= 1'b0;
      rd_eof     <= 1'b0;
      err_orphan <= 1'b0;
    end else if (rd_accept) begin
      if (rd_tag) begin
        rem    <= rem_load_c;
        rd_sof <= 1'b1;
        rd_eof <= 1'b0;
      end else if (rem != '0) begin
        rem    <= rem - (LEN_W+1)'(1);
        rd_sof <= 1'b0;
        rd_eof <= (rem == (LEN_W+1)'(1));
      end else begin
        rd_sof     <= 1'b0;
        rd_eof     <= 1'b0;
        err_orphan <= 1'b1;
      end
    end else begin
      rd_sof <= 1'b0;
      rd_eof <= 1'b0;
    end
  end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware channel FIFO: tagged storage, pointers, occupancy and sticky error flags.
module router_pkt_fifo import router_pkg::*; #(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned LEN_LSB   = LEN_LSB_DEF,
  parameter int unsigned LEN_W     = LEN_W_DEF,
  parameter int unsigned AF_MARGIN = AF_MARGIN_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  router_pkt_fifo_if.slave  bus
);

  localparam int unsigned AW       = addr_w(DEPTH);
  localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - AF_MARGIN);

  typedef struct packed {
    logic              sof;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  fifo_entry_t       mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       count;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              err_overflow;
  logic              err_underflow;

  logic              empty_c;
  logic              full_c;
  logic              wr_acc_c;
  logic              rd_acc_c;
  fifo_entry_t       rd_entry_c;

  assign empty_c    = (wr_ptr == rd_ptr);
  assign full_c     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_acc_c   = bus.write_enb && !full_c && !soft_reset;
  assign rd_acc_c   = bus.read_enb && !empty_c && !soft_reset;
  assign rd_entry_c = mem[rd_ptr[AW-1:0]];

  // Storage write; contents survive reset and become unreachable via the pointers.
  always_ff @(posedge clock) begin
    if (wr_acc_c) mem[wr_ptr[AW-1:0]] <= '{sof: bus.lfd_state, data: bus.data_in};
  end

  // Pointers, occupancy, registered read data and sticky overflow/underflow.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      rd_valid      <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      rd_valid      <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_acc_c) begin
        rd_ptr   <= rd_ptr + (AW+1)'(1);
        data_out <= rd_entry_c.data;
      end
      rd_valid <= rd_acc_c;
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (bus.write_enb && full_c) err_overflow <= 1'b1;
      if (bus.read_enb && empty_c) err_underflow <= 1'b1;
    end
  end

  router_pkt_tracker #(
    .LEN_W (LEN_W)
  ) u_tracker (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .rd_accept  (rd_acc_c),
    .rd_tag     (rd_entry_c.sof),
    .rd_len     (rd_entry_c.data[LEN_LSB +: LEN_W]),
    .rd_sof     (bus.rd_sof),
    .rd_eof     (bus.rd_eof),
    .pkt_active (bus.pkt_active),
    .err_orphan (bus.err_orphan)
  );

  assign bus.data_out      = data_out;
  assign bus.rd_valid      = rd_valid;
  assign bus.empty         = empty_c;
  assign bus.full          = full_c;
  assign bus.almost_full   = (count >= AF_LEVEL);
  assign bus.count         = count;
  assign bus.err_overflow  = err_overflow;
  assign bus.err_underflow = err_underflow;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo at default parameters.
module tb_router_pkt_fifo;
  import router_pkg::*;

  localparam int DEPTH = 16;

  logic clock;
  logic resetn;
  logic soft_reset;

  router_pkt_fifo_if #(.DATA_W(8), .DEPTH(DEPTH)) bus ();

  router_pkt_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  entry_t     sb_q[$];
  int         mcount;
  int         mrem;
  logic [7:0] m_dout;
  bit         m_ovf, m_unf, m_orph;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    sb_q.delete();
    mcount = 0;
    mrem   = 0;
    m_dout = '0;
    m_ovf  = 0;
    m_unf  = 0;
    m_orph = 0;
  endtask

  task automatic check_outputs(input bit ra, input bit esof, input bit eeof);
    chk("rd_valid",      32'(bus.rd_valid),      32'(ra));
    chk("rd_sof",        32'(bus.rd_sof),        32'(esof));
    chk("rd_eof",        32'(bus.rd_eof),        32'(eeof));
    chk("data_out",      32'(bus.data_out),      32'(m_dout));
    chk("count",         32'(bus.count),         32'(mcount));
    chk("empty",         32'(bus.empty),         32'(mcount == 0));
    chk("full",          32'(bus.full),          32'(mcount == DEPTH));
    chk("almost_full",   32'(bus.almost_full),   32'(mcount >= DEPTH - 2));
    chk("pkt_active",    32'(bus.pkt_active),    32'(mrem != 0));
    chk("err_overflow",  32'(bus.err_overflow),  32'(m_ovf));
    chk("err_underflow", 32'(bus.err_underflow), 32'(m_unf));
    chk("err_orphan",    32'(bus.err_orphan),    32'(m_orph));
  endtask

  // One clock of stimulus; the model decides acceptance and expected markers.
  task automatic step(input logic we, input logic lfd, input logic [7:0] din,
                      input logic re, input logic sr = 1'b0);
    bit     wa, ra, esof, eeof;
    entry_t e;
    bus.write_enb = we;
    bus.lfd_state = lfd;
    bus.data_in   = din;
    bus.read_enb  = re;
    soft_reset    = sr;
    wa = 0; ra = 0; esof = 0; eeof = 0;
    if (sr) begin
      model_clear();
    end else begin
      wa = we && (mcount < DEPTH);
      ra = re && (mcount > 0);
      if (we && mcount == DEPTH) m_ovf = 1;
      if (re && mcount == 0) m_unf = 1;
      if (ra) begin
        e = sb_q.pop_front();
        m_dout = e.data;
        if (e.sof) begin
          mrem = int'(e.data[7:2]) + 1;
          esof = 1;
        end else if (mrem != 0) begin
          eeof = (mrem == 1);
          mrem--;
        end else begin
          m_orph = 1;
        end
      end
      if (wa) sb_q.push_back('{sof: lfd, data: din});
      mcount = mcount + int'(wa) - int'(ra);
    end
    @(posedge clock);
    #1;
    check_outputs(ra, esof, eeof);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Async reset asserted between edges; outputs must clear without a clock.
  task automatic apply_reset();
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in   = '0;
    bus.read_enb  = 1'b0;
    soft_reset    = 1'b0;
    @(negedge clock);
    #2;
    resetn = 1'b0;
    #1;
    model_clear();
    check_outputs(1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn        = 1'b0;
    soft_reset    = 1'b0;
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in   = '0;
    bus.read_enb  = 1'b0;
    model_clear();
    apply_reset();

    // Single packet: header len 3, three payload words, parity.
    step(1, 1, 8'h0D, 0);
    step(1, 0, 8'hA1, 0);
    step(1, 0, 8'hA2, 0);
    step(1, 0, 8'hA3, 0);
    step(1, 0, 8'hC3, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);
    idle();

    // Fill to full, overflow, read+write at full, then drain past empty.
    for (int i = 0; i < DEPTH; i++) step(1, (i == 0), 8'(8'h40 + i), 0);
    step(1, 0, 8'hEE, 0);
    step(1, 0, 8'hDD, 1);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 8'h00, 1);
    idle();

    // Read+write at mid occupancy and at empty.
    apply_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h10 + i), 0);
    step(1, 0, 8'h18, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1);
    step(1, 0, 8'h77, 1);
    step(0, 0, 8'h00, 1);
    idle();

    // Soft reset mid-packet with remaining count 2, write pending the same cycle.
    apply_reset();
    step(0, 0, 8'h00, 1);
    step(1, 1, 8'h0D, 0);
    step(1, 0, 8'hB1, 0);
    step(1, 0, 8'hB2, 0);
    step(1, 0, 8'hB3, 0);
    step(1, 0, 8'hB4, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    step(1, 0, 8'h55, 1, 1);
    idle();

    // Async reset with live data in the FIFO.
    step(1, 1, 8'h08, 0);
    step(1, 0, 8'h66, 0);
    step(0, 0, 8'h00, 1);
    apply_reset();
    idle();

    // Orphan word, then a zero-length header followed by its parity word.
    step(1, 0, 8'h5A, 0);
    step(0, 0, 8'h00, 1);
    step(1, 1, 8'h00, 0);
    step(1, 0, 8'h99, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
Parametrised, packet-aware FIFO for the router output channels; the successor to the fixed 16x8 channel FIFO.
- Stores a start-of-packet tag with each word.
- Tracks remaining packet length on the read side, with registered read valid and sof/eof markers.
- Provides occupancy, almost-full and sticky error flags.
- No tri-state output.
- Sits between the router register/FSM write side and one destination read port; one instance per channel.

Parameters:
DATA_W, 8, data word width.
DEPTH, 16, number of entries; power of 2, >=4.
LEN_LSB, 2, LSB position of the payload-length field in the header word.
LEN_W, 6, width of the payload-length field; LEN_LSB+LEN_W <= DATA_W.
AF_MARGIN, 2, almost_full asserts when count >= DEPTH-AF_MARGIN; 1..DEPTH-1.

Ports:
clock  in  1  single clock, rising edge.
resetn  in  1  asynchronous active-low reset.
soft_reset  in  1  synchronous clear, active high.
write_enb  in  1  write request.
lfd_state  in  1  marks data_in as packet header (sof tag).
data_in  in  DATA_W  write data.
read_enb  in  1  read request.
data_out  out  DATA_W  registered read data.
rd_valid  out  1  data_out updated this cycle.
rd_sof  out  1  data_out is a header word.
rd_eof  out  1  data_out is last word of packet (parity).
empty  out  1  no entries.
full  out  1  DEPTH entries.
almost_full  out  1  count >= DEPTH-AF_MARGIN.
count  out  AW+1  occupancy, AW=clog2(DEPTH).
pkt_active  out  1  packet partially read (remaining count != 0).
err_overflow  out  1  sticky: write_enb while full.
err_underflow  out  1  sticky: read_enb while empty.
err_orphan  out  1  sticky: untagged word read with no packet active.

Behaviour:
- Reset (resetn low, async) and soft_reset (sync):
  - Pointers, count, data_out, rd_valid, rd_sof, rd_eof, remaining counter and all error flags go to 0.
  - empty=1, full=0.
  - Memory contents are not cleared; they are unreachable because pointers reset.
  - soft_reset has priority over write/read in the same cycle.
- Storage: DEPTH x (DATA_W+1); bit DATA_W holds lfd_state captured at write.
- Pointers: wr_ptr/rd_ptr are AW+1 bits and wrap naturally.
  - empty = pointers equal.
  - full = MSBs differ, low bits equal.
  - Both flags are combinational from registered pointers.
- Write accepted iff write_enb && !full. The entry is written, wr_ptr+1.
- Read accepted iff read_enb && !empty. rd_ptr+1.
- Read latency is 1 cycle:
  - data_out <= mem[rd] data; rd_valid=1 next cycle only.
  - data_out holds its value when no read is accepted.
- Simultaneous read+write:
  - When neither full nor empty: both accepted, count unchanged.
  - When full: only the read is accepted, err_overflow sets.
  - When empty: only the write is accepted, err_underflow sets; the write is not bypassed to data_out.
- count: +1 on accepted write only, -1 on accepted read only.
- Packet tracking (remaining counter rem, LEN_W+1 bits), on an accepted read:
  - Tagged word: rem <= len+1 (payload+parity), rd_sof=1. A tagged word arriving while rem != 0 restarts rem; no error.
  - Untagged word, rem != 0: rem-1; rd_eof=1 when rem==1.
  - Untagged word, rem == 0: data is still output, err_orphan sets, rd_sof=rd_eof=0.
  - Length 0 header: next read is parity with rd_eof=1.
  - rd_sof/rd_eof are valid only with rd_valid; they are 0 otherwise.
- Error flags clear only on reset/soft_reset.

Decomposition:
- router_pkg holds:
  - header field constants LEN_LSB/LEN_W defaults;
  - the clog2-based AW function;
  - a typedef for the tagged entry {sof, data}.
- One sub-module, router_pkt_tracker: the rem counter and sof/eof/orphan logic, driven by the read-accept strobe and the read entry.
- The FIFO top keeps storage, pointers, count and flags.

Test Plan:
- After reset, write header 8'h0D (len 3) with lfd_state=1, then 3 payload words and parity; read 5 -> data in order; rd_sof on 1st, rd_eof on 5th; pkt_active 1 between them; count 5->0.
- Write 16 words with write_enb held -> full=1 and count=16; almost_full from count=14; 17th write -> err_overflow=1, contents unchanged.
- Drain past empty -> err_underflow=1, rd_valid=0, data_out holds last value.
- At full, read+write same cycle -> only the read is accepted, count=15. At count 8, read+write -> count stays 8. With the FIFO empty, write+read -> count=1, rd_valid=0.
- Assert soft_reset mid-packet at rem=2 -> next cycle empty=1, count=0, pkt_active=0, flags clear. Pulse resetn low asynchronously between clock edges -> outputs clear immediately.
- Read an untagged word first -> err_orphan=1, data output. Then header 8'h00 -> following word carries rd_eof=1.
